// File: rtl/input_cmd_scheduler.sv
// Button front end for the game logic: synchronise, debounce, auto-repeat, and
// round-robin arbitration of move requests onto a single valid/ready command stream.
module input_cmd_scheduler #(
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 15000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       button_down,
    input  logic       button_rotate,
    input  logic       button_left,
    input  logic       button_right,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    output logic [3:0] pressed
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LOAD = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LOAD  = RPT_W'(REPEAT_RATE - 1);
    localparam logic             RAW_IDLE   = (BTN_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    logic [3:0] raw;
    logic [3:0] stable;
    logic [3:0] set_req;
    logic [3:0] pending;
    logic [3:0] pending_next;
    logic [3:0] grant_mask;
    logic [1:0] ptr;
    logic [1:0] grant_idx;
    logic [1:0] probe;
    logic       load;

    // Bit index doubles as the command code: 0 down, 1 rotate, 2 left, 3 right.
    assign raw     = {button_right, button_left, button_rotate, button_down};
    assign pressed = stable;

    genvar i;
    for (i = 0; i < 4; i++) begin : g_btn
        logic            sync_p0;
        logic            sync_p1;
        logic            level;
        logic            stable_lvl;
        logic            stable_dly;
        logic [DB_W-1:0] db_cnt;

        // Stage p0/p1: two-flop synchroniser, then debounce against the stable level.
        always_ff @(posedge clk_50 or negedge reset_n) begin
            if (!reset_n) begin
                sync_p0    <= RAW_IDLE;
                sync_p1    <= RAW_IDLE;
                stable_lvl <= 1'b0;
                stable_dly <= 1'b0;
                db_cnt     <= '0;
            end else begin
                sync_p0    <= raw[i];
                sync_p1    <= sync_p0;
                stable_dly <= stable_lvl;
                if (level != stable_lvl) begin
                    if (db_cnt == DB_LAST) begin
                        stable_lvl <= level;
                        db_cnt     <= '0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end else begin
                    db_cnt <= '0;
                end
            end
        end

        assign level     = sync_p1 ^ RAW_IDLE;
        assign stable[i] = stable_lvl;

        if (i == 1) begin : g_no_rpt
            assign set_req[i] = stable_lvl & ~stable_dly;
        end else begin : g_rpt
            rpt_state_t       state;
            rpt_state_t       state_next;
            logic [RPT_W-1:0] cnt;
            logic [RPT_W-1:0] cnt_next;
            logic             fire;
            logic             press_edge;
            logic             release_edge;

            assign press_edge   = stable_lvl & ~stable_dly;
            assign release_edge = ~stable_lvl & stable_dly;

            always_ff @(posedge clk_50 or negedge reset_n) begin
                if (!reset_n) begin
                    state <= RPT_IDLE;
                    cnt   <= '0;
                end else begin
                    state <= state_next;
                    cnt   <= cnt_next;
                end
            end

            // Release has priority, so a repeat due on the release cycle is dropped.
            always_comb begin
                state_next = state;
                cnt_next   = cnt;
                fire       = 1'b0;
                if (release_edge) begin
                    state_next = RPT_IDLE;
                    cnt_next   = '0;
                end else begin
                    case (state)
                        RPT_IDLE: begin
                            if (press_edge) begin
                                state_next = RPT_DELAY;
                                cnt_next   = DELAY_LOAD;
                            end
                        end
                        RPT_DELAY, RPT_REPEAT: begin
                            if (cnt == '0) begin
                                state_next = RPT_REPEAT;
                                cnt_next   = RATE_LOAD;
                                fire       = 1'b1;
                            end else begin
                                cnt_next = cnt - 1'b1;
                            end
                        end
                        default: begin
                            state_next = RPT_IDLE;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end

            assign set_req[i] = press_edge | fire;
        end
    end

    // Round-robin pick: scanning offsets high to low leaves the nearest pending bit.
    always_comb begin
        load      = (!cmd_valid || cmd_ready) && (|pending);
        grant_idx = ptr;
        probe     = ptr;
        for (int k = 3; k >= 0; k--) begin
            probe = ptr + 2'(k);
            if (pending[probe]) begin
                grant_idx = probe;
            end
        end
        grant_mask   = load ? (4'b0001 << grant_idx) : 4'b0000;
        pending_next = (pending & ~grant_mask) | set_req;
    end

    // Stage p2: pending latch and the output command register.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= '0;
            ptr       <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
        end else begin
            pending <= pending_next;
            if (load) begin
                cmd_valid <= 1'b1;
                cmd_code  <= grant_idx;
                ptr       <= grant_idx + 2'd1;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_input_cmd_scheduler.sv
// Scoreboard bench for input_cmd_scheduler: directed scenarios plus randomized button
// traffic, predicted by a timeline model of debounce, repeat schedule and round-robin grant.
module tb_input_cmd_scheduler;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic       clk_50 = 1'b0;
    logic       reset_n = 1'b1;
    logic       button_down = 1'b0;
    logic       button_rotate = 1'b0;
    logic       button_left = 1'b0;
    logic       button_right = 1'b0;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic [3:0] pressed;

    input_cmd_scheduler #(
        .BTN_ACTIVE_LOW (0),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk_50       (clk_50),
        .reset_n      (reset_n),
        .button_down  (button_down),
        .button_rotate(button_rotate),
        .button_left  (button_left),
        .button_right (button_right),
        .cmd_ready    (cmd_ready),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .pressed      (pressed)
    );

    always #5 clk_50 = ~clk_50;

    int  tests = 0;
    int  fails = 0;
    int  xfer_cnt = 0;
    int  xfer_log[$];
    int  exp_q[$];
    bit  chk_en = 1'b0;
    bit  drv_rn = 1'b0;

    bit [3:0] m_syn1, m_syn2, m_stable, m_pend;
    int       m_run[4];
    int       m_rise[4];
    bit       m_valid;
    int       m_ptr;
    int       m_t = 0;

    function automatic void check(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_syn1   = '0;
        m_syn2   = '0;
        m_stable = '0;
        m_pend   = '0;
        m_valid  = 1'b0;
        m_ptr    = 0;
        for (int b = 0; b < 4; b++) begin
            m_run[b]  = 0;
            m_rise[b] = 0;
        end
        exp_q.delete();
    endfunction

    // Predicts the state after the coming clock edge from the inputs just driven.
    function automatic void model_step();
        bit [3:0] raw, set_m, gmask;
        int       k, g;
        if (!reset_n) begin
            model_reset();
            return;
        end
        raw = {button_right, button_left, button_rotate, button_down};
        m_t++;
        set_m = '0;
        gmask = '0;
        // Requests: press at rise+1, then (not rotate) rise+1+RD+n*RR while still held.
        for (int b = 0; b < 4; b++) begin
            if (m_stable[b]) begin
                k = m_t - m_rise[b] - 1;
                if (k == 0) set_m[b] = 1'b1;
                else if (b != 1 && k >= RD && ((k - RD) % RR) == 0) set_m[b] = 1'b1;
            end
        end
        // Level accepted after D consecutive disagreeing cycles.
        for (int b = 0; b < 4; b++) begin
            if (m_syn2[b] != m_stable[b]) begin
                m_run[b]++;
                if (m_run[b] == D) begin
                    m_stable[b] = ~m_stable[b];
                    m_run[b]    = 0;
                    if (m_stable[b]) m_rise[b] = m_t;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_syn2 = m_syn1;
        m_syn1 = raw;
        if ((!m_valid || cmd_ready) && m_pend != 0) begin
            g = -1;
            for (int n = 0; n < 4; n++) begin
                if (g < 0 && m_pend[(m_ptr + n) % 4]) g = (m_ptr + n) % 4;
            end
            exp_q.push_back(g);
            gmask[g] = 1'b1;
            m_valid  = 1'b1;
            m_ptr    = (g + 1) % 4;
        end else if (m_valid && cmd_ready) begin
            m_valid = 1'b0;
        end
        m_pend = (m_pend & ~gmask) | set_m;
    endfunction

    task automatic cycle(input bit [3:0] b, input bit r);
        @(negedge clk_50);
        reset_n = drv_rn;
        {button_right, button_left, button_rotate, button_down} = b;
        cmd_ready = r;
        model_step();
    endtask

    task automatic do_reset();
        drv_rn = 1'b0;
        repeat (3) cycle(4'b0000, 1'b1);
        drv_rn = 1'b1;
        xfer_cnt = 0;
        xfer_log.delete();
    endtask

    // Monitor: transfers pop the scoreboard; levels compared every cycle.
    initial begin
        bit         pv;
        logic [1:0] pc;
        pv = 1'b0;
        pc = '0;
        forever begin
            @(posedge clk_50);
            #1;
            if (chk_en) begin
                if (reset_n && pv && cmd_ready) begin
                    xfer_cnt++;
                    xfer_log.push_back(int'(pc));
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL xfer_unexpected: got code %0d, expected none at %0t", pc, $time);
                    end else begin
                        check("xfer_code", int'(pc), exp_q.pop_front());
                    end
                end
                if (reset_n && pv && !cmd_ready) begin
                    check("stall_valid", int'(cmd_valid), 1);
                    check("stall_code", int'(cmd_code), int'(pc));
                end
                check("valid", int'(cmd_valid), int'(m_valid));
                check("pressed", int'(pressed), int'(m_stable));
            end
            pv = reset_n ? cmd_valid : 1'b0;
            pc = cmd_code;
        end
    end

    initial begin
        bit [3:0] cur;
        bit [3:0] glitch;
        model_reset();
        #1 reset_n = 1'b0;
        drv_rn = 1'b0;
        repeat (3) cycle(4'b0000, 1'b1);
        check("reset_valid", int'(cmd_valid), 0);
        check("reset_code", int'(cmd_code), 0);
        check("reset_pressed", int'(pressed), 0);
        chk_en = 1'b1;
        drv_rn = 1'b1;

        // Left held 60 cycles: press plus repeats at 27,35,43,51,59.
        do_reset();
        for (int c = 0; c < 80; c++) cycle((c < 60) ? 4'b0100 : 4'b0000, 1'b1);
        check("t1_xfers", xfer_cnt, 6);

        // Down bouncing with 3-cycle runs never settles.
        do_reset();
        for (int c = 0; c < 40; c++) cycle((c < 30 && ((c / 3) % 2) == 0) ? 4'b0001 : 4'b0000, 1'b1);
        check("t2_xfers", xfer_cnt, 0);

        // All four at once, output stalled until edge 20, then drained in round-robin order.
        do_reset();
        for (int c = 0; c < 40; c++) cycle((c < 10) ? 4'b1111 : 4'b0000, c >= 20);
        check("t3_xfers", xfer_cnt, 4);
        for (int n = 0; n < 4 && n < xfer_log.size(); n++) check("t3_order", xfer_log[n], n);

        // Rotate never auto-repeats.
        do_reset();
        for (int c = 0; c < 120; c++) cycle((c < 100) ? 4'b0010 : 4'b0000, 1'b1);
        check("t4_xfers", xfer_cnt, 1);

        // Right stalled until edge 50: held command, collapsed repeats (re-set at 50), repeat at 58.
        do_reset();
        for (int c = 0; c < 90; c++) cycle((c < 60) ? 4'b1000 : 4'b0000, c >= 50);
        check("t5_xfers", xfer_cnt, 4);

        // Asynchronous reset while a command is waiting.
        do_reset();
        for (int c = 0; c < 9; c++) cycle((c < 6) ? 4'b0001 : 4'b0000, 1'b0);
        @(posedge clk_50);
        #3;
        check("t6_pre_valid", int'(cmd_valid), 1);
        drv_rn  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("t6_async_valid", int'(cmd_valid), 0);
        check("t6_async_pressed", int'(pressed), 0);
        repeat (3) cycle(4'b0000, 1'b1);
        drv_rn   = 1'b1;
        xfer_cnt = 0;
        for (int c = 0; c < 40; c++) cycle(4'b0000, 1'b1);
        check("t6_xfers", xfer_cnt, 0);

        // Random traffic: long holds, single-cycle glitches, random stalls, rare resets.
        do_reset();
        cur = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 79) == 0) cur[b] = ~cur[b];
            end
            glitch = ($urandom_range(0, 59) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            drv_rn = ($urandom_range(0, 1499) != 0);
            cycle(cur ^ glitch, $urandom_range(0, 9) < 7);
        end
        drv_rn = 1'b1;
        for (int c = 0; c < 60; c++) cycle(4'b0000, 1'b1);
        check("drain_queue", exp_q.size(), 0);
        check("drain_valid", int'(cmd_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
